// File: rtl/aes_pkg.sv
// Shared AES arithmetic, state encodings and round-key helpers for the
// forward and inverse round controllers.
package aes_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_KEXP = 3'd1,
    ST_INIT = 3'd2,
    ST_ISHI = 3'd3,
    ST_ISUB = 3'd4,
    ST_IADD = 3'd5,
    ST_IMIX = 3'd6
  } state_t;

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = xtime(t);
    end
    return p;
  endfunction

  // x^254 by an addition chain; maps 0 to 0 as the S-box requires
  function automatic logic [7:0] gf_inv(input logic [7:0] x);
    logic [7:0] x2, x3, x12, x15, x240;
    x2   = gf_mul(x, x);
    x3   = gf_mul(x2, x);
    x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
    x15  = gf_mul(x12, x3);
    x240 = gf_mul(x15, x15);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    x240 = gf_mul(x240, x240);
    return gf_mul(gf_mul(x240, x12), x2);
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] i;
    i = gf_inv(x);
    return i ^ {i[6:0], i[7]} ^ {i[5:0], i[7:6]} ^ {i[4:0], i[7:5]} ^
           {i[3:0], i[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] x);
    return gf_inv({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05);
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n0 = k[127:96] ^ sub_word(rot_word(k[31:0])) ^ {rc, 24'h0};
    n1 = k[95:64] ^ n0;
    n2 = k[63:32] ^ n1;
    n3 = k[31:0] ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  // Exact inverse of key_expand: recovers the previous round key
  function automatic logic [127:0] key_unexpand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] n0, n1, n2, n3;
    n3 = k[31:0] ^ k[63:32];
    n2 = k[63:32] ^ k[95:64];
    n1 = k[95:64] ^ k[127:96];
    n0 = k[127:96] ^ sub_word(rot_word(n3)) ^ {rc, 24'h0};
    return {n0, n1, n2, n3};
  endfunction

  // byte s(r,c) lives at [127-8*(4c+r) -: 8]
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++)
      o[8*b +: 8] = inv_sbox(s[8*b +: 8]);
    return o;
  endfunction

endpackage

// File: rtl/inv_mix_col32.sv
// InvMixColumns on one column; row 0 is the most significant byte.
module inv_mix_col32
  import aes_pkg::*;
(
  input  logic [31:0] col,
  output logic [31:0] mixed
);

  logic [7:0] a0, a1, a2, a3;
  assign {a0, a1, a2, a3} = col;

  assign mixed[31:24] = gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3);
  assign mixed[23:16] = gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3);
  assign mixed[15:8]  = gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3);
  assign mixed[7:0]   = gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3);

endmodule

// File: rtl/aes_inv_round.sv
// Iterative AES-128 inverse cipher, one step per clock.
// AES_INV_DIRECTKEY_EN: KEY is taken as K10 and key expansion is skipped.
module aes_inv_round
  import aes_pkg::*;
(
  input  logic         clk,
  input  logic         res,
  input  logic         start,
  input  logic [127:0] IN,
  input  logic [127:0] KEY,
  output logic         busy,
  output logic         done,
  output logic [127:0] OUT
);

  state_t       state;
  logic [127:0] data;
  logic [127:0] key;
  logic [3:0]   r;
  logic [127:0] mix_data;

  genvar c;
  generate
    for (c = 0; c < 4; c++) begin : g_col
      inv_mix_col32 u_col (
        .col  (data[(3-c)*32 +: 32]),
        .mixed(mix_data[(3-c)*32 +: 32])
      );
    end
  endgenerate

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= ST_IDLE;
      data  <= '0;
      key   <= '0;
      r     <= '0;
      OUT   <= '0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: if (start) begin
          data <= IN;
          key  <= KEY;
          busy <= 1'b1;
`ifdef AES_INV_DIRECTKEY_EN
          r     <= 4'd10;
          state <= ST_INIT;
`else
          r     <= 4'd0;
          state <= ST_KEXP;
`endif
        end
        ST_KEXP: begin
          key <= key_expand(key, rcon(r + 4'd1));
          r   <= r + 4'd1;
          if (r == 4'd9) state <= ST_INIT;
        end
        ST_INIT: begin
          data  <= data ^ key;
          state <= ST_ISHI;
        end
        ST_ISHI: begin
          data  <= inv_shift_rows(data);
          state <= ST_ISUB;
        end
        // key register walks back one round key alongside the data
        ST_ISUB: begin
          data  <= inv_sub_bytes(data);
          key   <= key_unexpand(key, rcon(r));
          r     <= r - 4'd1;
          state <= ST_IADD;
        end
        ST_IADD: begin
          data <= data ^ key;
          if (r == 4'd0) begin
            OUT   <= data ^ key;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else begin
            state <= ST_IMIX;
          end
        end
        ST_IMIX: begin
          data  <= mix_data;
          state <= ST_ISHI;
        end
        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_inv_round.sv
// Directed bench for aes_inv_round using FIPS-197 vectors.
module tb_aes_inv_round;

  logic         clk;
  logic         res;
  logic         start;
  logic [127:0] IN;
  logic [127:0] KEY;
  logic         busy;
  logic         done;
  logic [127:0] OUT;

  int checks = 0;
  int errors = 0;

  localparam logic [127:0] C1_IN  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_OUT = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] B_IN   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_OUT  = 128'h3243f6a8885a308d313198a2e0370734;
`ifdef AES_INV_DIRECTKEY_EN
  localparam int           LAT    = 41;
  localparam logic [127:0] C1_KEY = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
`else
  localparam int           LAT    = 51;
  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
`endif

  aes_inv_round dut (
    .clk  (clk),
    .res  (res),
    .start(start),
    .IN   (IN),
    .KEY  (KEY),
    .busy (busy),
    .done (done),
    .OUT  (OUT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // accepting edge E0; returns 1 time unit after it
  task automatic launch(input logic [127:0] in_v, input logic [127:0] key_v);
    start = 1'b1;
    IN    = in_v;
    KEY   = key_v;
    @(posedge clk); #1;
    start = 1'b0;
    IN    = '0;
    KEY   = '0;
  endtask

  task automatic wait_result(input string name, input logic [127:0] exp, input bit inject,
                             input bit chain, input logic [127:0] c_in, input logic [127:0] c_key);
    int  n;
    bit  seen, busy_ok;
    n = 0; seen = 0; busy_ok = 1;
    while (!seen && n < LAT + 8) begin
      @(posedge clk); #1;
      n++;
      if (inject) begin
        if (n == 4 || n == 29) begin
          start = 1'b1; IN = B_IN; KEY = B_KEY;
        end else begin
          start = 1'b0;
        end
      end
      if (done === 1'b1) seen = 1;
      else if (busy !== 1'b1) busy_ok = 0;
    end
    start = 1'b0;
    checks++;
    if (!busy_ok) begin
      errors++; $display("FAIL %s busy: dropped before done", name);
    end
    checks++;
    if (!seen) begin
      errors++; $display("FAIL %s timeout: no done within %0d edges", name, LAT + 8);
      return;
    end
    checks++;
    if (n != LAT - 1) begin
      errors++; $display("FAIL %s latency: got done after %0d edges, expected %0d", name, n, LAT - 1);
    end
    checks++;
    if (OUT !== exp) begin
      errors++; $display("FAIL %s out: got %h expected %h", name, OUT, exp);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL %s busy_at_done: got %b expected 0", name, busy);
    end
    if (chain) begin
      start = 1'b1; IN = c_in; KEY = c_key;
      @(posedge clk); #1;
      start = 1'b0; IN = '0; KEY = '0;
      checks++;
      if (done !== 1'b0 || busy !== 1'b1) begin
        errors++; $display("FAIL %s chain_accept: done=%b busy=%b expected 0/1", name, done, busy);
      end
    end else begin
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (done !== 1'b0 || OUT !== exp) begin
        errors++; $display("FAIL %s hold: done=%b out=%h expected 0/%h", name, done, OUT, exp);
      end
    end
  endtask

  task automatic test_reset();
    res = 1'b0; start = 1'b0; IN = '0; KEY = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b expected 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b expected 0", done); end
    checks++;
    if (OUT !== 128'h0) begin errors++; $display("FAIL reset out: got %h expected 0", OUT); end
    @(negedge clk);
    res = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_vector_c1();
    launch(C1_IN, C1_KEY);
    wait_result("c1", C1_OUT, 0, 0, '0, '0);
  endtask

  task automatic test_vector_b();
    launch(B_IN, B_KEY);
    wait_result("appb", B_OUT, 0, 0, '0, '0);
  endtask

  task automatic test_back_to_back();
    launch(C1_IN, C1_KEY);
    wait_result("ignore_start", C1_OUT, 1, 1, B_IN, B_KEY);
    wait_result("chained", B_OUT, 0, 0, '0, '0);
  endtask

  task automatic test_mid_reset();
    int  n;
    bit  stray;
    launch(C1_IN, C1_KEY);
    repeat (24) @(posedge clk);
    @(posedge clk); #1;
    res = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || OUT !== 128'h0) begin
      errors++; $display("FAIL mid_reset outputs: busy=%b done=%b out=%h expected 0/0/0", busy, done, OUT);
    end
    @(negedge clk);
    res = 1'b1;
    stray = 0;
    for (n = 0; n < LAT + 8; n++) begin
      @(posedge clk); #1;
      if (done !== 1'b0 || busy !== 1'b0) stray = 1;
    end
    checks++;
    if (stray) begin errors++; $display("FAIL mid_reset stray: activity after abort, expected none"); end
    launch(B_IN, B_KEY);
    wait_result("after_reset", B_OUT, 0, 0, '0, '0);
  endtask

  initial begin
    test_reset();
    test_vector_c1();
    test_vector_b();
    test_back_to_back();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
